// File: rtl/ets_pkg.sv
// Shared types and default constants for the ETS frame sequencer.
// The write-side FSM encoding lives here so the block and its bench agree on it.
package ets_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC     = 3'd1,
    ACK     = 3'd2,
    WRITE   = 3'd3,
    INC     = 3'd4,
    CHECK   = 3'd5,
    REQUEST = 3'd6
  } state_e;

  localparam int ETS_MAX_DEPTH    = 448;
  localparam int ETS_AVG_LOG2_MAX = 4;

endpackage

// File: rtl/ets_tap_accumulator.sv
// Per-tap sample accumulator with sample counter and power-of-two shift-divide.
// Extra AVG_LOG2_MAX headroom bits mean a full-scale 2^AVG_LOG2_MAX-sample sum never overflows.
module ets_tap_accumulator
  import ets_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int AVG_LOG2_MAX = ETS_AVG_LOG2_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accEn_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        avg_i,
  output logic              lastSample_o,
  output logic [DATA_W-1:0] wrData_o
);

  localparam int ACC_W = DATA_W + AVG_LOG2_MAX;
  localparam int CNT_W = AVG_LOG2_MAX + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cntInc;
  logic [CNT_W-1:0] target;

  assign cntInc       = cnt_q + CNT_W'(1);
  assign target       = CNT_W'(1) << avg_i;
  // Tells the FSM that the sample being accumulated now completes the tap.
  assign lastSample_o = (cntInc == target);
  assign wrData_o     = DATA_W'(acc_q >> avg_i);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accEn_i) begin
      acc_d = acc_q + ACC_W'(data_i);
      cnt_d = cntInc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ets_frame_sequencer.sv
// Write-side sequencer for the ETS capture path: handshakes samples in, averages per tap,
// writes taps into the frame buffer and requests a buffer swap at the end of each frame.
module ets_frame_sequencer
  import ets_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int MAX_DEPTH    = ETS_MAX_DEPTH,
  parameter int AVG_LOG2_MAX = ETS_AVG_LOG2_MAX,
  parameter int WR_CYCLES    = 2
) (
  input  logic              shifting_clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] frame_len_i,
  input  logic [2:0]        avg_log2_i,
  input  logic              core_valid_i,
  input  logic [DATA_W-1:0] core_data_i,
  output logic              core_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              buf_request_o,
  input  logic              buf_grant_i,
  input  logic              ps_done_i,
  output logic [31:0]       phase_counter_o,
  output logic [15:0]       frame_count_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(MAX_DEPTH);
  localparam logic [2:0]        AVG_MAX = 3'(AVG_LOG2_MAX);
  localparam logic [1:0]        WR_LAST = 2'(WR_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [2:0]        avg_q, avg_d;
  logic              midFrame_q, midFrame_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [1:0]        wrCnt_q, wrCnt_d;
  logic [15:0]       frameCount_q, frameCount_d;
  logic [31:0]       phaseCounter_q, phaseCounter_d;

  logic              accEn;
  logic              accClr;
  logic              lastSample;
  logic [ADDR_W-1:0] lenClamped;
  logic [2:0]        avgClamped;

  assign lenClamped = ((frame_len_i == '0) || (frame_len_i > LEN_MAX)) ? LEN_MAX : frame_len_i;
  assign avgClamped = (avg_log2_i > AVG_MAX) ? AVG_MAX : avg_log2_i;

  ets_tap_accumulator #(
    .DATA_W       (DATA_W),
    .AVG_LOG2_MAX (AVG_LOG2_MAX)
  ) u_acc (
    .clk_i        (shifting_clk_i),
    .rst_i        (reset_i),
    .accEn_i      (accEn),
    .clr_i        (accClr),
    .data_i       (core_data_i),
    .avg_i        (avg_q),
    .lastSample_o (lastSample),
    .wrData_o     (wr_data_o)
  );

  // midFrame_q separates "next sample of this frame" from "start of a new frame",
  // which is the only point where enable and the config inputs are looked at.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    avg_d         = avg_q;
    midFrame_d    = midFrame_q;
    wrAddr_d      = wrAddr_q;
    wrCnt_d       = wrCnt_q;
    frameCount_d  = frameCount_q;
    accEn         = 1'b0;
    accClr        = 1'b0;
    core_ready_o  = 1'b0;
    wr_en_o       = 1'b0;
    buf_request_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_valid_i) begin
          if (midFrame_q) begin
            state_d = ACC;
          end else if (enable_i) begin
            len_d      = lenClamped;
            avg_d      = avgClamped;
            midFrame_d = 1'b1;
            state_d    = ACC;
          end
        end
      end
      ACC: begin
        accEn   = 1'b1;
        state_d = lastSample ? WRITE : ACK;
      end
      ACK: begin
        core_ready_o = 1'b1;
        if (!core_valid_i) state_d = IDLE;
      end
      WRITE: begin
        wr_en_o = 1'b1;
        if (wrCnt_q == WR_LAST) begin
          wrCnt_d = '0;
          state_d = INC;
        end else begin
          wrCnt_d = wrCnt_q + 2'd1;
        end
      end
      INC: begin
        wrAddr_d = wrAddr_q + ADDR_W'(1);
        accClr   = 1'b1;
        state_d  = CHECK;
      end
      CHECK: begin
        if (wrAddr_q == len_q) begin
          wrAddr_d = '0;
          state_d  = REQUEST;
        end else begin
          state_d = ACK;
        end
      end
      // The sample that closed the frame is only acknowledged once a fresh buffer is granted.
      REQUEST: begin
        buf_request_o = 1'b1;
        wrAddr_d      = '0;
        if (buf_grant_i) begin
          frameCount_d = frameCount_q + 16'd1;
          midFrame_d   = 1'b0;
          state_d      = ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign phaseCounter_d = ps_done_i ? (phaseCounter_q + 32'd1) : phaseCounter_q;

  always_ff @(posedge shifting_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      len_q          <= '0;
      avg_q          <= '0;
      midFrame_q     <= 1'b0;
      wrAddr_q       <= '0;
      wrCnt_q        <= '0;
      frameCount_q   <= '0;
      phaseCounter_q <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      avg_q          <= avg_d;
      midFrame_q     <= midFrame_d;
      wrAddr_q       <= wrAddr_d;
      wrCnt_q        <= wrCnt_d;
      frameCount_q   <= frameCount_d;
      phaseCounter_q <= phaseCounter_d;
    end
  end

  assign wr_addr_o       = wrAddr_q;
  assign frame_count_o   = frameCount_q;
  assign phase_counter_o = phaseCounter_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ets_frame_sequencer.sv
// Directed bench for ets_frame_sequencer: drives four-phase sample handshakes and
// checks writes, frame swaps and statistics against hand-computed values.
module tb_ets_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [8:0]  frameLen;
  logic [2:0]  avgLog2;
  logic        coreValid;
  logic [31:0] coreData;
  logic        coreReady;
  logic        wrEn;
  logic [8:0]  wrAddr;
  logic [31:0] wrData;
  logic        bufRequest;
  logic        bufGrant;
  logic        psDone;
  logic [31:0] phaseCounter;
  logic [15:0] frameCount;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  logic [8:0]  bAddr[$];
  logic [31:0] bData[$];
  int          bLen[$];
  int          reqEdges = 0;
  int          unstable = 0;
  int          curLen   = 0;
  logic        prevWrEn = 1'b0;
  logic        prevReq  = 1'b0;

  int rl, wl, base, reqBase, c;
  logic sawReady, sawBusy;

  always #5 clk = ~clk;

  ets_frame_sequencer dut (
    .shifting_clk_i  (clk),
    .reset_i         (reset),
    .enable_i        (enable),
    .frame_len_i     (frameLen),
    .avg_log2_i      (avgLog2),
    .core_valid_i    (coreValid),
    .core_data_i     (coreData),
    .core_ready_o    (coreReady),
    .wr_en_o         (wrEn),
    .wr_addr_o       (wrAddr),
    .wr_data_o       (wrData),
    .buf_request_o   (bufRequest),
    .buf_grant_i     (bufGrant),
    .ps_done_i       (psDone),
    .phase_counter_o (phaseCounter),
    .frame_count_o   (frameCount),
    .busy_o          (busy)
  );

  // Burst monitor: one entry per wr_en burst, address/data captured on the first cycle.
  always @(negedge clk) begin
    if (wrEn && !prevWrEn) begin
      bAddr.push_back(wrAddr);
      bData.push_back(wrData);
      curLen = 1;
    end else if (wrEn) begin
      curLen++;
      if (wrData != bData[bData.size()-1] || wrAddr != bAddr[bAddr.size()-1]) unstable++;
    end else if (prevWrEn) begin
      bLen.push_back(curLen);
    end
    if (bufRequest && !prevReq) reqEdges++;
    prevWrEn = wrEn;
    prevReq  = bufRequest;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete four-phase handshake; latencies are in cycles from valid rising (-1 if never seen).
  task automatic applyStimulus(input logic [31:0] data, input int budget, output int readyLat, output int wrLat);
    coreData  = data;
    coreValid = 1'b1;
    readyLat  = -1;
    wrLat     = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (wrLat < 0 && wrEn) wrLat = k;
      if (coreReady) begin
        readyLat = k;
        break;
      end
    end
    coreValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulsePs();
    psDone = 1'b1;
    @(negedge clk);
    psDone = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; frameLen = 9'd4; avgLog2 = 3'd0;
    coreValid = 1'b0; coreData = '0; bufGrant = 1'b0; psDone = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady",   coreReady,    0);
    checkOutput("rstWrEn",    wrEn,         0);
    checkOutput("rstWrAddr",  wrAddr,       0);
    checkOutput("rstWrData",  wrData,       0);
    checkOutput("rstBufReq",  bufRequest,   0);
    checkOutput("rstPhase",   phaseCounter, 0);
    checkOutput("rstFrames",  frameCount,   0);
    checkOutput("rstBusy",    busy,         0);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // Single tap, no averaging: latency and write burst shape.
    base = bAddr.size();
    applyStimulus(32'h1234_5678, 40, rl, wl);
    checkOutput("t1WrLat",    wl, 2);
    checkOutput("t1ReadyLat", rl, 6);
    checkOutput("t1Bursts",   bAddr.size() - base, 1);
    checkOutput("t1Addr",     bAddr[base], 0);
    checkOutput("t1Data",     bData[base], 32'h1234_5678);
    checkOutput("t1Len",      bLen[bLen.size()-1], 2);
    checkOutput("t1AddrAfter", wrAddr, 1);

    // Config changed mid-frame must not affect the current frame.
    frameLen = 9'd2;
    avgLog2  = 3'd2;
    applyStimulus(32'h0000_000A, 40, rl, wl);
    applyStimulus(32'h0000_000B, 40, rl, wl);
    checkOutput("t1MidCfgLat", rl, 6);

    // Fourth sample closes the frame; swap is held off by buf_grant.
    coreData  = 32'h0000_000C;
    coreValid = 1'b1;
    c = 0;
    while (!bufRequest && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput("t1ReqSeen",   bufRequest, 1);
    checkOutput("t1ReqCycle",  c, 6);
    checkOutput("t1ReqAddr",   wrAddr, 0);
    checkOutput("t1Bursts4",   bAddr.size() - base, 4);
    checkOutput("t1LastAddr",  bAddr[bAddr.size()-1], 3);
    sawReady = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sawReady |= coreReady;
    end
    checkOutput("t1NoReadyNoGrant", sawReady, 0);
    checkOutput("t1ReqHeld", bufRequest, 1);
    bufGrant = 1'b1;
    @(negedge clk);
    bufGrant = 1'b0;
    checkOutput("t1ReadyAfterGrant", coreReady, 1);
    checkOutput("t1FrameCount", frameCount, 1);
    coreValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t1ReqOnce", reqEdges, 1);

    // Averaging by 4 over a 2-tap frame.
    bufGrant = 1'b1;
    base = bAddr.size();
    applyStimulus(32'd10, 40, rl, wl);
    checkOutput("t2AccReadyLat", rl, 2);
    applyStimulus(32'd20, 40, rl, wl);
    applyStimulus(32'd30, 40, rl, wl);
    applyStimulus(32'd40, 40, rl, wl);
    applyStimulus(32'd1, 40, rl, wl);
    applyStimulus(32'd1, 40, rl, wl);
    applyStimulus(32'd1, 40, rl, wl);
    applyStimulus(32'd5, 40, rl, wl);
    checkOutput("t2Bursts", bAddr.size() - base, 2);
    checkOutput("t2Addr0",  bAddr[base],   0);
    checkOutput("t2Data0",  bData[base],   25);
    checkOutput("t2Addr1",  bAddr[base+1], 1);
    checkOutput("t2Data1",  bData[base+1], 2);
    checkOutput("t2Frames", frameCount, 2);

    // frame_len=0 means the maximum depth of 448 taps.
    frameLen = 9'd0;
    avgLog2  = 3'd0;
    base    = bAddr.size();
    reqBase = reqEdges;
    for (int i = 0; i < 448; i++) begin
      applyStimulus(32'(i), 40, rl, wl);
      if (i == 446) checkOutput("t3NoReqBefore448", reqEdges - reqBase, 0);
    end
    checkOutput("t3Req448",    reqEdges - reqBase, 1);
    checkOutput("t3Writes448", bAddr.size() - base, 448);
    checkOutput("t3LastAddr",  bAddr[bAddr.size()-1], 447);
    checkOutput("t3LastData",  bData[bData.size()-1], 447);
    checkOutput("t3Frames",    frameCount, 3);

    // avg_log2=7 clamps to 4: 16 samples per write, sum 360 -> 22.
    frameLen = 9'd1;
    avgLog2  = 3'd7;
    base = bAddr.size();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(32'(3 * i), 40, rl, wl);
      if (i == 14) checkOutput("t3NoWriteBefore16", bAddr.size() - base, 0);
    end
    checkOutput("t3Avg16Writes", bAddr.size() - base, 1);
    checkOutput("t3Avg16Data",   bData[bData.size()-1], 22);

    // Full-scale averaging must not overflow the accumulator.
    avgLog2 = 3'd4;
    base = bAddr.size();
    for (int i = 0; i < 16; i++) applyStimulus(32'hFFFF_FFFF, 40, rl, wl);
    checkOutput("t3FullScaleWrites", bAddr.size() - base, 1);
    checkOutput("t3FullScaleData",   bData[bData.size()-1], 32'hFFFF_FFFF);
    checkOutput("t3Frames5", frameCount, 5);

    // Reset after 3 of 4 samples discards the partial frame.
    pulsePs();
    pulsePs();
    checkOutput("t4PhaseBefore", phaseCounter, 2);
    frameLen = 9'd4;
    avgLog2  = 3'd0;
    bufGrant = 1'b0;
    reqBase  = reqEdges;
    applyStimulus(32'd7, 40, rl, wl);
    applyStimulus(32'd8, 40, rl, wl);
    applyStimulus(32'd9, 40, rl, wl);
    checkOutput("t4AddrBeforeRst", wrAddr, 3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t4RstAddr",   wrAddr,       0);
    checkOutput("t4RstBusy",   busy,         0);
    checkOutput("t4RstReq",    bufRequest,   0);
    checkOutput("t4RstFrames", frameCount,   0);
    checkOutput("t4RstPhase",  phaseCounter, 0);
    checkOutput("t4RstData",   wrData,       0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t4NoReq", reqEdges - reqBase, 0);
    bufGrant = 1'b1;
    base = bAddr.size();
    for (int i = 0; i < 4; i++) applyStimulus(32'(100 + i), 40, rl, wl);
    checkOutput("t4NewAddr0",  bAddr[base],   0);
    checkOutput("t4NewData0",  bData[base],   100);
    checkOutput("t4NewAddr3",  bAddr[base+3], 3);
    checkOutput("t4NewFrames", frameCount, 1);

    // ps_done interleaved with handshakes, then enable=0 blocks a new frame.
    frameLen = 9'd5;
    for (int i = 0; i < 5; i++) begin
      pulsePs();
      applyStimulus(32'(i), 40, rl, wl);
    end
    checkOutput("t5Phase",  phaseCounter, 5);
    checkOutput("t5Frames", frameCount,   2);
    enable    = 1'b0;
    coreValid = 1'b1;
    sawReady  = 1'b0;
    sawBusy   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sawReady |= coreReady;
      sawBusy  |= busy;
    end
    coreValid = 1'b0;
    checkOutput("t5DisabledReady", sawReady, 0);
    checkOutput("t5DisabledBusy",  sawBusy,  0);

    checkOutput("wrDataStable", unstable, 0);
    checkOutput("burstLenAll", bLen[bLen.size()-1], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ets_frame_sequencer.md
Name: ets_frame_sequencer

Overview:
- Parametrised next-generation write-side sequencer for the equivalent-time-sampling (ETS) capture path.
- Accepts one sample per valid/ready four-phase handshake from the ETS core and writes it to the current frame buffer. Optionally averages 2^avg_log2 consecutive samples per tap before the write.
- At end of a frame (runtime-configurable length), requests a buffer swap from the triple-buffer controller and waits for the grant.
- Also keeps phase-step, frame and sample-count statistics.

Parameters:
- DATA_W, 32, width of core_data and wr_data.
- ADDR_W, 9, width of wr_addr and frame_len.
- MAX_DEPTH, 448, largest legal frame length in taps.
- AVG_LOG2_MAX, 4, maximum value of avg_log2; accumulator is DATA_W+AVG_LOG2_MAX bits.
- WR_CYCLES, 2, number of cycles wr_en is held per tap write (1..4).

Ports:
- shifting_clk, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- enable, in, 1, allows a new frame to start.
- frame_len, in, ADDR_W, taps per frame; sampled at frame start.
- avg_log2, in, 3, log2 of samples averaged per tap; sampled at frame start.
- core_valid, in, 1, ETS core has a sample.
- core_data, in, DATA_W, sample value; stable while core_valid is high.
- core_ready, out, 1, sample consumed; held until core_valid falls.
- wr_en, out, 1, buffer write strobe.
- wr_addr, out, ADDR_W, buffer tap address.
- wr_data, out, DATA_W, value written.
- buf_request, out, 1, frame complete, swap requested.
- buf_grant, in, 1, controller has a fresh write buffer (frame_ready).
- ps_done, in, 1, phase-shift step completed (1-cycle pulse).
- phase_counter, out, 32, count of ps_done pulses.
- frame_count, out, 16, count of completed frames.
- busy, out, 1, high when the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, accumulator 0, sample counter 0.
- Frame start: in IDLE, when enable=1 and core_valid=1, the block latches
  - len_q = frame_len, with 0 or values above MAX_DEPTH replaced by MAX_DEPTH;
  - avg_q = min(avg_log2, AVG_LOG2_MAX).
- If enable=0, IDLE ignores core_valid and core_ready stays 0. Deasserting enable mid-frame completes the frame.
- FSM states and transitions:
  - IDLE → ACC on the frame-start condition, or on core_valid when mid-frame.
  - ACC: acc += zero-extended core_data; smp_cnt += 1. If smp_cnt reaches 2^avg_q → WRITE, else → ACK.
  - ACK: core_ready=1; on core_valid=0 → IDLE (await next sample, same tap).
  - WRITE: wr_en=1 for WR_CYCLES cycles with wr_data = acc >> avg_q (low DATA_W bits), stable; then → INC.
  - INC: wr_addr += 1; acc and smp_cnt cleared; → CHECK.
  - CHECK: if wr_addr == len_q → REQUEST, else → ACK.
  - REQUEST: buf_request=1, wr_addr cleared to 0. On buf_grant=1: frame_count += 1 (wraps) → ACK.
- Handshake rules:
  - core_ready is never high in the same cycle a sample is accumulated.
  - Each sample is accumulated exactly once.
  - The core cannot present a new sample until core_ready has been seen and core_valid dropped.
- Latency:
  - avg_q = 0: core_valid rise → wr_en at +2 cycles → core_ready at +2+WR_CYCLES+2.
  - End-of-frame path: core_ready is additionally delayed by the REQUEST wait.
- Accumulator: avg_q=4 with full-scale data cannot overflow (DATA_W+4 bits).
- phase_counter increments on every ps_done independently of FSM state, wraps at 2^32.
- Simultaneous clr and increment of wr_addr cannot occur; clr has priority by construction.
- Reset mid-frame: everything returns to reset values immediately; a partial frame is discarded, with no buf_request.
- Config changes mid-frame have no effect until the next frame start.
- Unknown state encoding → IDLE.

Decomposition:
- Package ets_pkg holds:
  - state enum: IDLE, ACC, ACK, WRITE, INC, CHECK, REQUEST;
  - default constants MAX_DEPTH=448 and AVG_LOG2_MAX=4.
- One sub-module, ets_tap_accumulator: accumulator, sample counter and shift-divide.
- The FSM, address counter and statistics counters stay in the top level.

Test Plan:
- Single tap, avg_log2=0, WR_CYCLES=2, core_data=0x12345678 → wr_en high 2 cycles at wr_addr=0 with wr_data=0x12345678; core_ready rises 6 cycles after core_valid; wr_addr=1 after.
- frame_len=4, avg_log2=0, 4 samples → 4th write is followed by buf_request=1 and wr_addr=0. Hold buf_grant=0 for 10 cycles → core_ready stays 0. Pulse buf_grant → frame_count=1 and core_ready rises.
- avg_log2=2, frame_len=2, samples 10,20,30,40,1,1,1,5 → writes 25 at addr 0 and 2 at addr 1; only 2 wr_en bursts.
- frame_len=0 → buf_request after exactly 448 writes. avg_log2=7 → behaves as 4 (16 samples per write).
- Assert reset for 1 cycle after 3 of 4 samples → all outputs 0, no buf_request. A next 4-sample frame starts at wr_addr=0.
- 5 ps_done pulses interleaved with handshakes → phase_counter=5. enable=0 with core_valid=1 → core_ready stays 0 and busy=0.
